jk_excite_ctrl: RTL and testbench

//  Inverse of a JK flip-flop: given a requested next-state word, derives the
//  per-bit J/K excitation needed to move an external WIDTH-bit bank of JK flops

---
 rtl/jk_excite_ctrl.sv | 115 +++++++++++
 tb/tb_jk_excite_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_ctrl.sv
// jk_excite_ctrl: derives one cycle of J/K excitation that moves an external
// bank of JK flops from its present state (q_fb) to a requested target, then
// watches the bank until it matches (done) or gives up after TIMEOUT cycles (err).
module jk_excite_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TOGGLE  = 0,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_tgt,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             jk_en,
  output logic             done,
  output logic             err,
  input  logic             clr_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, ERROR} state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] tgt_r, tgt_n;
  logic [WIDTH-1:0] j_n, k_n, diff;
  logic [CW-1:0]    cnt, cnt_n;
  logic             jk_en_n, done_n, err_n;

  // Only IDLE can take a new target; the done cycle is still IDLE so it accepts too.
  assign in_ready = (state == IDLE);

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_n = state;
    tgt_n   = tgt_r;
    cnt_n   = cnt;
    j_n     = '0;
    k_n     = '0;
    jk_en_n = 1'b0;
    done_n  = 1'b0;
    err_n   = err;
    diff    = in_tgt ^ q_fb;
    case (state)
      IDLE: begin
        if (in_valid) begin
          tgt_n = in_tgt;
          if (diff == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = DRIVE;
            jk_en_n = 1'b1;
            if (TOGGLE != 0) begin
              j_n = diff;
              k_n = diff;
            end else begin
              j_n = diff & in_tgt;
              k_n = diff & ~in_tgt;
            end
          end
        end
      end
      DRIVE: begin
        cnt_n   = '0;
        state_n = CHECK;
      end
      CHECK: begin
        if (q_fb == tgt_r) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          state_n = ERROR;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ERROR: begin
        if (clr_err) begin
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tgt_r <= '0;
      cnt   <= '0;
      j_o   <= '0;
      k_o   <= '0;
      jk_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      tgt_r <= tgt_n;
      cnt   <= cnt_n;
      j_o   <= j_n;
      k_o   <= k_n;
      jk_en <= jk_en_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// tb_jk_excite_ctrl: drives a hold-excitation instance and a toggle-excitation
// instance side by side, each feeding its own modelled JK flop bank.
module tb_jk_excite_ctrl;

  localparam int W  = 8;
  localparam int TO = 4;

  logic         clk, rst, in_valid, clr_err;
  logic [W-1:0] in_tgt;
  logic [W-1:0] q0, q1, j0, k0, j1, k1;
  logic         in_ready0, in_ready1, jk_en0, jk_en1, done0, done1, err0, err1;
  logic         load, stuck;
  logic [W-1:0] loadVal;

  int compareCount = 0;
  int failCount    = 0;

  jk_excite_ctrl #(.WIDTH(W), .TOGGLE(0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_tgt(in_tgt), .q_fb(q0), .j_o(j0), .k_o(k0), .jk_en(jk_en0),
    .done(done0), .err(err0), .clr_err(clr_err));

  jk_excite_ctrl #(.WIDTH(W), .TOGGLE(1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_tgt(in_tgt), .q_fb(q1), .j_o(j1), .k_o(k1), .jk_en(jk_en1),
    .done(done1), .err(err1), .clr_err(clr_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External JK flop banks: preloadable, and freezable to emulate a stuck bank.
  always @(posedge clk) begin
    if (load) begin
      q0 <= loadVal;
      q1 <= loadVal;
    end else if (!stuck) begin
      q0 <= (j0 & ~q0) | (~k0 & q0);
      q1 <= (j1 & ~q1) | (~k1 & q1);
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference excitation, bit by bit from the JK excitation table.
  task automatic refExcite(input logic [W-1:0] q, input logic [W-1:0] t, input bit tog,
                           output logic [W-1:0] ej, output logic [W-1:0] ek);
    ej = '0;
    ek = '0;
    for (int i = 0; i < W; i++) begin
      if (q[i] != t[i]) begin
        ej[i] = tog ? 1'b1 : t[i];
        ek[i] = tog ? 1'b1 : ~t[i];
      end
    end
  endtask

  task automatic loadBank(input logic [W-1:0] v);
    load = 1'b1;
    loadVal = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // One full transaction from an IDLE negedge back to an IDLE negedge.
  task automatic applyStimulus(input logic [W-1:0] tgt, input bit stk);
    logic [W-1:0] qb, ej0, ek0, ej1, ek1;
    qb = q0;
    refExcite(qb, tgt, 1'b0, ej0, ek0);
    refExcite(qb, tgt, 1'b1, ej1, ek1);
    stuck = stk;
    in_valid = 1'b1;
    in_tgt = tgt;
    @(negedge clk);
    in_valid = 1'b0;
    in_tgt = 8'($urandom);
    if (tgt == qb) begin
      checkOutput("sameDone0", 16'(done0), 16'd1);
      checkOutput("sameDone1", 16'(done1), 16'd1);
      checkOutput("sameNoEn", 16'({jk_en0, jk_en1}), 16'd0);
      checkOutput("sameReady", 16'(in_ready0), 16'd1);
    end else begin
      checkOutput("drvEn", 16'({jk_en0, jk_en1}), 16'h3);
      checkOutput("drvJ0", 16'(j0), 16'(ej0));
      checkOutput("drvK0", 16'(k0), 16'(ek0));
      checkOutput("drvJ1", 16'(j1), 16'(ej1));
      checkOutput("drvK1", 16'(k1), 16'(ek1));
      checkOutput("drvBusy", 16'({in_ready0, done0}), 16'd0);
      @(negedge clk);
      checkOutput("chkEnOff", 16'({jk_en0, jk_en1, j0, k0}), 16'd0);
      checkOutput("chkQ0", 16'(q0), 16'(stk ? qb : tgt));
      checkOutput("chkQ1", 16'(q1), 16'(stk ? qb : tgt));
      if (!stk) begin
        @(negedge clk);
        checkOutput("doneBoth", 16'({done0, done1}), 16'h3);
        checkOutput("doneNoErr", 16'({err0, err1}), 16'd0);
        checkOutput("doneReady", 16'(in_ready0), 16'd1);
      end else begin
        for (int c = 0; c < TO; c++) begin
          @(negedge clk);
          checkOutput("toErr", 16'(err0), 16'(c == TO - 1));
          checkOutput("toNoDone", 16'(done0), 16'd0);
        end
        checkOutput("toErr1", 16'(err1), 16'd1);
        checkOutput("toNotReady", 16'({in_ready0, in_ready1}), 16'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checkOutput("clrErr", 16'({err0, err1}), 16'd0);
        checkOutput("clrReady", 16'({in_ready0, in_ready1}), 16'h3);
      end
    end
    stuck = 1'b0;
    @(negedge clk);
    checkOutput("pulseEnd", 16'({done0, done1}), 16'd0);
  endtask

  // Directed scenarios, then randomized transactions.
  initial begin
    logic [W-1:0] seq [3];
    logic [W-1:0] t;
    int cyc;
    bit got, stk;
    seq[0] = 8'h01; seq[1] = 8'h03; seq[2] = 8'h02;
    rst = 1'b1; in_valid = 1'b0; clr_err = 1'b0; in_tgt = '0;
    load = 1'b0; stuck = 1'b0; loadVal = '0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rstOuts", 16'({jk_en0, done0, err0, jk_en1, done1, err1}), 16'd0);
    checkOutput("rstJK", 16'({j0, k0}), 16'd0);
    @(negedge clk);
    loadBank(8'h00);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstReady", 16'({in_ready0, in_ready1}), 16'h3);

    $display("[TB] hold/toggle excitation 0F -> 3C");
    loadBank(8'h0F);
    applyStimulus(8'h3C, 1'b0);

    $display("[TB] already at target A5");
    loadBank(8'hA5);
    applyStimulus(8'hA5, 1'b0);

    $display("[TB] stuck bank timeout");
    loadBank(8'h00);
    applyStimulus(8'hFF, 1'b1);

    $display("[TB] reset mid-CHECK");
    stuck = 1'b1;
    in_valid = 1'b1;
    in_tgt = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstOuts", 16'({jk_en0, done0, err0, jk_en1, done1, err1}), 16'd0);
    checkOutput("midRstJK", 16'({j0, k0}), 16'd0);
    @(negedge clk);
    checkOutput("midRstNoDone", 16'({done0, done1}), 16'd0);
    stuck = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstReady", 16'({in_ready0, in_ready1}), 16'h3);
    checkOutput("midRstIdle", 16'({done0, err0}), 16'd0);

    $display("[TB] back-to-back with in_valid held");
    loadBank(8'h00);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_tgt = seq[i];
      checkOutput("b2bReady", 16'(in_ready0), 16'd1);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 10) begin
        @(negedge clk);
        cyc++;
        if (done0) got = 1'b1;
      end
      checkOutput("b2bDone", 16'(got), 16'd1);
      checkOutput("b2bLatency", 16'(cyc), 16'd3);
      checkOutput("b2bQ", 16'(q0), 16'(seq[i]));
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2bFinalQ", 16'(q1), 16'h02);
    checkOutput("b2bQuiet", 16'({done0, jk_en0}), 16'd0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      t = 8'($urandom);
      if ($urandom_range(0, 4) == 0) t = q0;
      stk = ($urandom_range(0, 7) == 0);
      applyStimulus(t, stk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
